// File: rtl/rate_pacer_pkg.sv
// Shared widths and mode helpers for the rate pacer.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package rate_pacer_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_GAP_WIDTH   = 8;
    localparam int DEF_BURST_WIDTH = 4;

    // Pacing is off when disabled or when a zero gap is programmed.
    function automatic logic calc_bypass(input logic pace_enable,
                                         input logic [31:0] gap_cycles);
        return !pace_enable || (gap_cycles == 32'd0);
    endfunction

    // A zero burst length still allows a single token in the bucket.
    function automatic logic [31:0] calc_eff_burst(input logic [31:0] burst_len);
        return (burst_len == 32'd0) ? 32'd1 : burst_len;
    endfunction

endpackage

// File: rtl/rate_pacer_if.sv
// Ready/valid link carrying the paced payload.
// Latency: n/a (wires only).
// Backpressure: ready travels from slave side back to master side.
interface rate_pacer_if
    import rate_pacer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/pacer_token_bucket.sv
// Token bucket: gap counter earns one token per gap_cycles, saturating at eff_burst.
// Latency: token changes appear one cycle after the causing edge.
// Backpressure: none; spend is asserted only when a token exists.
module pacer_token_bucket
    import rate_pacer_pkg::*;
#(
    parameter int GAP_WIDTH   = DEF_GAP_WIDTH,
    parameter int BURST_WIDTH = DEF_BURST_WIDTH
) (
    input  logic                   clock_port,
    input  logic                   reset_port,
    input  logic                   spend,
    input  logic                   bypass,
    input  logic [GAP_WIDTH-1:0]   gap_cycles,
    input  logic [BURST_WIDTH-1:0] burst_len,
    output logic [BURST_WIDTH-1:0] tokens
);

    localparam logic [GAP_WIDTH-1:0]   GAP_ONE   = GAP_WIDTH'(1);
    localparam logic [BURST_WIDTH-1:0] TOKEN_ONE = BURST_WIDTH'(1);

    logic [BURST_WIDTH-1:0] eff_burst;
    logic [BURST_WIDTH-1:0] tokens_q;
    logic [BURST_WIDTH-1:0] tokens_d;
    logic [GAP_WIDTH-1:0]   wait_cnt;
    logic [GAP_WIDTH-1:0]   wait_cnt_d;
    logic                   advance;
    logic                   earn;
    logic                   over_cap;

    assign eff_burst = BURST_WIDTH'(calc_eff_burst(32'(burst_len)));
    assign tokens    = tokens_q;

    // Earn/spend decision; >= on the gap compare lets a shrunk gap earn at once.
    always_comb begin
        advance  = (tokens_q < eff_burst) | spend;
        earn     = advance & (wait_cnt >= (gap_cycles - GAP_ONE));
        over_cap = tokens_q > eff_burst;
    end

    // Next bucket state: bypass and burst shrink reload the bucket, otherwise earn/spend.
    always_comb begin
        tokens_d   = tokens_q;
        wait_cnt_d = wait_cnt;
        if (bypass || over_cap) begin
            tokens_d   = eff_burst;
            wait_cnt_d = '0;
        end else begin
            if (!advance || earn) begin
                wait_cnt_d = '0;
            end else begin
                wait_cnt_d = wait_cnt + GAP_ONE;
            end
            if (earn && !spend && (tokens_q < eff_burst)) begin
                tokens_d = tokens_q + TOKEN_ONE;
            end else if (spend && !earn) begin
                tokens_d = tokens_q - TOKEN_ONE;
            end
        end
    end

    // Bucket registers; reset empties the bucket regardless of traffic.
    always_ff @(posedge clock_port) begin
        if (reset_port) begin
            tokens_q <= '0;
            wait_cnt <= '0;
        end else begin
            tokens_q <= tokens_d;
            wait_cnt <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/rate_pacer.sv
// Inline ready/valid rate limiter: one transfer per gap_cycles, bursts up to burst_len.
// Latency: zero on data/valid/ready; token_count is registered (one cycle).
// Backpressure: ready/valid gated by token availability, never stores or drops data.
module rate_pacer
    import rate_pacer_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int GAP_WIDTH   = DEF_GAP_WIDTH,
    parameter int BURST_WIDTH = DEF_BURST_WIDTH
) (
    input  logic                   clock_port,
    input  logic                   reset_port,
    rate_pacer_if.slave            input_port,
    rate_pacer_if.master           output_port,
    input  logic                   pace_enable,
    input  logic [GAP_WIDTH-1:0]   gap_cycles,
    input  logic [BURST_WIDTH-1:0] burst_len,
    output logic [BURST_WIDTH-1:0] token_count
);

    logic                   bypass;
    logic                   allow;
    logic                   xfer;
    logic                   spend;
    logic [BURST_WIDTH-1:0] tokens;

    // Handshake gating: a token (or bypass) opens both directions of the link.
    always_comb begin
        bypass            = calc_bypass(pace_enable, 32'(gap_cycles));
        allow             = bypass | (tokens != '0);
        input_port.ready  = allow & output_port.ready;
        output_port.valid = allow & input_port.valid;
        output_port.data  = input_port.data;
        xfer              = input_port.valid & output_port.ready & allow;
        spend             = xfer & !bypass;
    end

    assign token_count = tokens;

    pacer_token_bucket #(
        .GAP_WIDTH   (GAP_WIDTH),
        .BURST_WIDTH (BURST_WIDTH)
    ) u_bucket (
        .clock_port (clock_port),
        .reset_port (reset_port),
        .spend      (spend),
        .bypass     (bypass),
        .gap_cycles (gap_cycles),
        .burst_len  (burst_len),
        .tokens     (tokens)
    );

endmodule

// File: doc/rate_pacer.md
# rate_pacer

Parametrised ready/valid rate limiter: forwards a DATA_WIDTH-bit stream from input to output while enforcing an average rate of one transfer per `gap_cycles` clocks, with bursts of up to `burst_len` back-to-back transfers. Successor to the fixed-width, fixed-gap pacer: runtime-programmable gap and burst, bypass mode, status output. Sits inline on any ready/valid link that needs throttling, e.g. in front of slow peripherals or shared buses.

## Interface
Parameters:
- DATA_WIDTH, 8, payload width
- GAP_WIDTH, 8, width of `gap_cycles` and of the internal gap counter
- BURST_WIDTH, 4, width of `burst_len` and of the token counter

Ports:
- clock_port  in  1  single clock, all state on rising edge
- reset_port  in  1  synchronous, active-high reset
- input_port_data  in  DATA_WIDTH  upstream payload
- input_port_valid  in  1  upstream valid
- input_port_ready  out  1  upstream ready
- output_port_data  out  DATA_WIDTH  downstream payload
- output_port_valid  out  1  downstream valid
- output_port_ready  in  1  downstream ready
- pace_enable  in  1  0 = bypass (ungated pass-through)
- gap_cycles  in  GAP_WIDTH  cycles per earned token; 0 treated as bypass
- burst_len  in  BURST_WIDTH  bucket capacity; 0 treated as 1
- token_count  out  BURST_WIDTH  current tokens in bucket

## Operation
- Data path purely combinational: `output_port_data = input_port_data`, no storage.
- `allow = bypass | (tokens != 0)`, where `bypass = !pace_enable | (gap_cycles == 0)`.
- `input_port_ready = allow & output_port_ready`; `output_port_valid = allow & input_port_valid`.
- `transfer = input_port_valid & output_port_ready & allow`.
- `eff_burst = (burst_len == 0) ? 1 : burst_len`.
- Gap counter `wait_cnt` advances when `tokens < eff_burst` or `transfer`; otherwise held at 0.
- Earn: counter advancing and `wait_cnt >= gap_cycles-1` (>= handles runtime shrink of gap) -> `wait_cnt <= 0`, token earned.
- Token update per cycle: earn & !spend -> +1; spend & !earn -> -1; both or neither -> unchanged. Spend = `transfer & !bypass`.
- Tokens saturate at `eff_burst`; earn never pushes tokens above `eff_burst`.
- Burst shrink at runtime: if `tokens > eff_burst`, next cycle tokens = `eff_burst` (clamp overrides earn/spend), `wait_cnt <= 0`.
- Bypass: gating removed; each cycle in bypass loads `tokens <= eff_burst`, `wait_cnt <= 0` so leaving bypass starts with full bucket.
- `token_count` = registered `tokens`.

## Timing
- Reset (reset_port high at an edge): `tokens = 0`, `wait_cnt = 0`; hence `token_count = 0`, and (when not in bypass) `input_port_ready = 0`, `output_port_valid = 0` in the first cycle after reset.
- Reset dominates all other updates, including mid-burst; in-flight handshakes in the reset cycle are not counted.
- Zero latency on data, valid and ready (combinational); token effects visible one cycle after the causing edge.
- After reset with gap G, burst B and no traffic: first token visible at cycle G (cycle 0 = first cycle after reset release).
- Steady state, continuous valid and ready: one transfer every G cycles.
- Idle with full bucket: up to `eff_burst` consecutive transfers, then one every G.
- Valid may be asserted without ready and vice versa; the block never drops or duplicates data (no storage, ready/valid passed through).

## Structure
- Package `rate_pacer_pkg`: default width constants, and a function computing `eff_burst` and `bypass`.
- One sub-module natural: `pacer_token_bucket` (gap counter + saturating token counter; inputs spend/bypass/gap/burst, outputs tokens). Top level holds only handshake gating and data path.

## Test plan
- Reset release, G=3, B=1, valid and ready held high -> transfers at cycles 3, 6, 9, ...; token_count toggles 0/1; data unchanged at output.
- G=4, B=3, valid low for 20 cycles (token_count reaches 3), then valid and ready high from cycle T -> transfers at T, T+1, T+2, T+4, T+8, T+12.
- G=3, B=2, bucket full, ready low with valid high for 10 cycles -> no transfer, token_count stays 2, output_port_valid=1, input_port_ready=0.
- pace_enable=0 with continuous traffic -> transfer every cycle, token_count = eff_burst; switch pace_enable to 1 with B=2, G=5 -> 2 back-to-back transfers then one per 5 cycles.
- Runtime change: B=8 full, then burst_len=2 -> token_count 2 next cycle; gap_cycles changed 10->2 while wait_cnt=6 -> token earned that cycle.
- reset_port asserted mid-burst (tokens=2) -> next cycle token_count=0, ready/valid low; first transfer G cycles after release; burst_len=0 behaves as 1.
